rx_point_test_tx_ctrl: RTL and testbench
========================================

# rx_point_test_tx_ctrl

Transmit-side controller for the RX-initiated data-to-clock point test in the mainband training LTSM. It runs the sideband request/response handshake with the partner, drives the mainband pattern generator, and reports completion to the LTSM. It adds three capabilities to the earlier single-shot controller:

- runtime-selectable pattern, burst, comparison mode and clock phase;
- N back-to-back iterations, each with its own LFSR-clear/count-done exchange;
- a response timeout with an error exit.

## Interface
- SB_MSG_WIDTH, 4: width of encoded/decoded sideband message codes
- ITER_WIDTH, 4: width of iteration count input/counter
- TIMEOUT_CYCLES, 8000: cycles allowed waiting for any sideband response (≥2)

- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_pt_en  in  1  LTSM enable; low forces return to IDLE
- i_valvref_sel  in  1  0: data vref test, 1: valid vref test
- i_pattern_sel  in  1  0: LFSR, 1: per-lane ID (ignored when i_valvref_sel=1)
- i_burst_sel  in  1  0: 1K, 1: 4K
- i_compare_mode  in  1  0: per-lane, 1: aggregate
- i_clock_phase  in  2  0: eye center, 1: left edge, 2: right edge
- i_iterations  in  ITER_WIDTH  iterations per test; 0 treated as 1
- i_pattern_finished  in  1  pulse from pattern generator
- i_decoded_SB_msg  in  SB_MSG_WIDTH  decoded partner message (valid for one cycle)
- i_falling_edge_busy  in  1  sideband finished sending current message
- i_rx_valid  in  1  RX-side controller currently using the sideband
- o_encoded_SB_msg_tx  out  SB_MSG_WIDTH  message code to sideband
- o_sb_data_pattern, o_sb_burst_count, o_sb_comparison_mode  out  1 each  sideband data fields
- o_clock_phase  out  2  sideband data field
- o_valid_tx  out  1  message request to wrapper
- o_mainband_pattern_generator_cw  out  2  00 idle, 01 clear LFSR, 10 LFSR, 11 per-lane ID
- o_val_pattern_en  out  1  valid-lane pattern enable
- o_iter_cnt  out  ITER_WIDTH  completed iterations
- o_pt_done_tx  out  1  test finished (success or error)
- o_pt_error  out  1  timeout occurred

## Operation

**Message codes:** START_REQ=1, START_RESP=2, LFSR_CLR_REQ=3, LFSR_CLR_RESP=4, COUNT_DONE_REQ=5, COUNT_DONE_RESP=6, END_REQ=7, END_RESP=8.

**States:** IDLE, START, CLR, SEND, CNT_DONE, END, DONE, ERROR.

Transitions:
- IDLE→START when i_pt_en.
- START→CLR on START_RESP.
- CLR→SEND on LFSR_CLR_RESP.
- SEND→CNT_DONE on i_pattern_finished.
- CNT_DONE→CLR on COUNT_DONE_RESP if iter+1 < eff_iter, where eff_iter = max(i_iterations,1). The iteration counter increments.
- CNT_DONE→END on COUNT_DONE_RESP if iter+1 ≥ eff_iter. The iteration counter increments.
- END→DONE on END_RESP.
- START, CLR, CNT_DONE or END → ERROR when the wait counter reaches TIMEOUT_CYCLES−1 with no matching response.
- DONE or ERROR → IDLE only when i_pt_en falls.
- Any state → IDLE when i_pt_en=0. This has priority over every other transition.

**Configuration:** all config inputs are latched on IDLE→START and held for the rest of the test.

**Wait counter:**
- Clears on every state entry.
- Counts in the four waiting states only.
- Never wraps.
- A response arriving in the same cycle as expiry wins over the timeout.

**Registered outputs on transitions:**
- IDLE→START: msg=1; data fields driven from latched config. o_sb_data_pattern = pattern_sel & ~valvref_sel.
- →CLR (from START or CNT_DONE): msg=3, cw=01.
- CLR→SEND:
  - data test: cw=10 (LFSR) or 11 (per-lane ID);
  - valid test: cw=00, o_val_pattern_en=1.
- SEND→CNT_DONE: msg=5, cw=00, o_val_pattern_en=0.
- CNT_DONE→END: msg=7.
- END→DONE: o_pt_done_tx=1.
- →ERROR: o_pt_done_tx=1, o_pt_error=1, cw=00, o_val_pattern_en=0.
- In IDLE: all outputs and the iteration counter return to reset values.

**Valid handshake:**
- o_valid_tx sets on each message-issuing transition (→START, →CLR, →CNT_DONE, →END).
- It clears on i_falling_edge_busy & ~i_rx_valid.
- Set wins if both occur in the same cycle.

**Unexpected input:** unexpected decoded messages are ignored.

## Timing
- **Reset:** every output is 0, the state is IDLE and the counters are 0. Reset takes effect asynchronously.
- **Latency:** every output changes exactly one cycle after the cycle in which the causing input is sampled.
  - i_pt_en rise → msg=1 and o_valid_tx=1 one cycle later.
  - Response → next request one cycle later.
  - i_pattern_finished → cw=00 and msg=5 one cycle later.
- **Timeout:** ERROR is entered TIMEOUT_CYCLES cycles after entering a waiting state.
- **Mid-test disable:** i_pt_en low in any state gives IDLE next cycle. Outputs clear one cycle after that.
- **Reset mid-test:** immediate return to reset values. No message is resent until a new enable.

## Test plan
Tests use TIMEOUT_CYCLES=16, ITER_WIDTH=4.

1. **Single data test, LFSR:** config data/LFSR/4K/per-lane/phase 0, iterations=1, responses 2, 4, pattern_finished, 6, 8 → message sequence 1, 3, 5, 7; cw 01→10→00; o_sb_burst_count=1; o_pt_done_tx=1, o_pt_error=0, o_iter_cnt=1.
2. **Valid test, 3 iterations:** iterations=3, i_valvref_sel=1 → the sequence 3, 5 occurs three times; o_val_pattern_en pulses three times; cw never 10/11; o_iter_cnt=3 at DONE.
3. **Timeout:** withhold LFSR_CLR_RESP → after 16 cycles in CLR, o_pt_error=1, o_pt_done_tx=1, cw=00. With the response arriving on cycle 15 instead, the test proceeds to SEND.
4. **Mid-test disable:** drop i_pt_en during SEND → IDLE next cycle; all outputs 0 one cycle later; re-enable restarts with msg=1.
5. **Valid handshake arbitration:** i_falling_edge_busy=1 with i_rx_valid=1 → o_valid_tx stays 1. Busy falling edge coinciding with a new request → o_valid_tx stays 1.
6. **Per-lane ID, zero iterations:** i_pattern_sel=1, iterations=0 → cw=11 in SEND, o_sb_data_pattern=1, exactly one iteration run. Asserting reset during END → all outputs 0 immediately.

Source files
------------

// File: rtl/rx_point_test_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// rx_point_test_tx_ctrl_if
//   Sideband message bundle between the point-test TX controller (master)
//   and the sideband wrapper (slave).
//
//   Request side (master -> slave):
//     o_encoded_SB_msg_tx   message code to send
//     o_valid_tx            message request
//     o_sb_data_pattern, o_sb_burst_count, o_sb_comparison_mode,
//     o_clock_phase         data fields carried with the request
//   Response side (slave -> master):
//     i_decoded_SB_msg      decoded partner message, valid for one cycle
//     i_falling_edge_busy   wrapper finished sending the current message
//     i_rx_valid            RX-side controller currently owns the sideband
//
//   Handshake: o_valid_tx rises when the master issues a message and stays
//   high until the wrapper reports i_falling_edge_busy while the RX side is
//   not using the sideband (i_rx_valid low); a new issue in that same cycle
//   keeps it high.
// ---------------------------------------------------------------------------
interface rx_point_test_tx_ctrl_if #(
  parameter int SB_MSG_WIDTH = 4
);
  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg;
  logic                    i_falling_edge_busy;
  logic                    i_rx_valid;
  logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx;
  logic                    o_sb_data_pattern;
  logic                    o_sb_burst_count;
  logic                    o_sb_comparison_mode;
  logic [1:0]              o_clock_phase;
  logic                    o_valid_tx;

  modport master (
    input  i_decoded_SB_msg, i_falling_edge_busy, i_rx_valid,
    output o_encoded_SB_msg_tx, o_sb_data_pattern, o_sb_burst_count,
           o_sb_comparison_mode, o_clock_phase, o_valid_tx
  );

  modport slave (
    output i_decoded_SB_msg, i_falling_edge_busy, i_rx_valid,
    input  o_encoded_SB_msg_tx, o_sb_data_pattern, o_sb_burst_count,
           o_sb_comparison_mode, o_clock_phase, o_valid_tx
  );
endinterface

// File: rtl/rx_point_test_tx_ctrl.sv
// ---------------------------------------------------------------------------
// rx_point_test_tx_ctrl
//   TX-side controller for the RX-initiated data-to-clock point test.
//   Runs START / LFSR_CLR / COUNT_DONE / END sideband exchanges with the
//   partner, drives the mainband pattern generator, repeats the
//   clear/send/count-done loop for the requested number of iterations and
//   exits with an error if any response takes too long.
//
//   Ports:
//     i_clk, i_rst          clock, asynchronous active-high reset
//     i_pt_en               LTSM enable; low returns to IDLE
//     i_valvref_sel, i_pattern_sel, i_burst_sel, i_compare_mode,
//     i_clock_phase, i_iterations
//                           test configuration, latched at test start
//     i_pattern_finished    pulse from the pattern generator
//     sb                    sideband bundle (master side)
//     o_mainband_pattern_generator_cw  00 idle, 01 clear, 10 LFSR, 11 lane ID
//     o_val_pattern_en      valid-lane pattern enable
//     o_iter_cnt            completed iterations
//     o_pt_done_tx          test finished (success or error)
//     o_pt_error            response timeout occurred
//     o_dbg_state           current FSM state
// ---------------------------------------------------------------------------
module rx_point_test_tx_ctrl #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int ITER_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_pt_en,
  input  logic                  i_valvref_sel,
  input  logic                  i_pattern_sel,
  input  logic                  i_burst_sel,
  input  logic                  i_compare_mode,
  input  logic [1:0]            i_clock_phase,
  input  logic [ITER_WIDTH-1:0] i_iterations,
  input  logic                  i_pattern_finished,
  rx_point_test_tx_ctrl_if.master sb,
  output logic [1:0]            o_mainband_pattern_generator_cw,
  output logic                  o_val_pattern_en,
  output logic [ITER_WIDTH-1:0] o_iter_cnt,
  output logic                  o_pt_done_tx,
  output logic                  o_pt_error,
  output logic [2:0]            o_dbg_state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_CLR   = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_CNT   = 3'd4;
  localparam logic [2:0] ST_END   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_ERROR = 3'd7;

  localparam logic [SB_MSG_WIDTH-1:0] MSG_START_REQ  = SB_MSG_WIDTH'(1);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_START_RESP = SB_MSG_WIDTH'(2);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_CLR_REQ    = SB_MSG_WIDTH'(3);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_CLR_RESP   = SB_MSG_WIDTH'(4);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_CNT_REQ    = SB_MSG_WIDTH'(5);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_CNT_RESP   = SB_MSG_WIDTH'(6);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_END_REQ    = SB_MSG_WIDTH'(7);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_END_RESP   = SB_MSG_WIDTH'(8);

  localparam logic [1:0] CW_IDLE = 2'b00;
  localparam logic [1:0] CW_CLR  = 2'b01;
  localparam logic [1:0] CW_LFSR = 2'b10;
  localparam logic [1:0] CW_ID   = 2'b11;

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]              state_q, state_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [ITER_WIDTH-1:0]   iter_q, iter_d;
  logic [ITER_WIDTH-1:0]   cfg_iter_q, cfg_iter_d;
  logic                    cfg_valvref_q, cfg_valvref_d;
  logic                    cfg_pattern_q, cfg_pattern_d;
  logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
  logic                    valid_q, valid_d;
  logic                    pat_q, pat_d;
  logic                    burst_q, burst_d;
  logic                    cmp_q, cmp_d;
  logic [1:0]              phase_q, phase_d;
  logic [1:0]              cw_q, cw_d;
  logic                    ven_q, ven_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    timeout;
  logic                    waiting;
  logic [ITER_WIDTH:0]     iter_next;
  logic [ITER_WIDTH:0]     eff_iter;

  assign timeout   = (wait_q == WAIT_MAX);
  assign waiting   = (state_q == ST_START) || (state_q == ST_CLR) ||
                     (state_q == ST_CNT)   || (state_q == ST_END);
  assign iter_next = {1'b0, iter_q} + (ITER_WIDTH+1)'(1);
  // A zero iteration request still runs one pass.
  assign eff_iter  = (cfg_iter_q == '0) ? (ITER_WIDTH+1)'(1) : {1'b0, cfg_iter_q};

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    iter_d        = iter_q;
    cfg_iter_d    = cfg_iter_q;
    cfg_valvref_d = cfg_valvref_q;
    cfg_pattern_d = cfg_pattern_q;
    msg_d         = msg_q;
    valid_d       = valid_q;
    pat_d         = pat_q;
    burst_d       = burst_q;
    cmp_d         = cmp_q;
    phase_d       = phase_q;
    cw_d          = cw_q;
    ven_d         = ven_q;
    done_d        = done_q;
    err_d         = err_q;

    // Wrapper release; any message issue below overrides it.
    if (sb.i_falling_edge_busy && !sb.i_rx_valid) valid_d = 1'b0;

    if (!i_pt_en) begin
      // Disable leaves outputs alone for one cycle; IDLE then clears them.
      state_d = ST_IDLE;
      if (state_q == ST_IDLE) begin
        iter_d = '0; cfg_iter_d = '0; cfg_valvref_d = 1'b0; cfg_pattern_d = 1'b0;
        msg_d = '0; valid_d = 1'b0; pat_d = 1'b0; burst_d = 1'b0; cmp_d = 1'b0;
        phase_d = 2'b00; cw_d = CW_IDLE; ven_d = 1'b0; done_d = 1'b0; err_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d       = ST_START;
          iter_d        = '0;
          cfg_iter_d    = i_iterations;
          cfg_valvref_d = i_valvref_sel;
          cfg_pattern_d = i_pattern_sel;
          msg_d         = MSG_START_REQ;
          valid_d       = 1'b1;
          pat_d         = i_pattern_sel & ~i_valvref_sel;
          burst_d       = i_burst_sel;
          cmp_d         = i_compare_mode;
          phase_d       = i_clock_phase;
          cw_d          = CW_IDLE;
          ven_d         = 1'b0;
          done_d        = 1'b0;
          err_d         = 1'b0;
        end
        ST_START: begin
          if (sb.i_decoded_SB_msg == MSG_START_RESP) begin
            state_d = ST_CLR; msg_d = MSG_CLR_REQ; cw_d = CW_CLR; valid_d = 1'b1;
          end else if (timeout) begin
            state_d = ST_ERROR;
          end
        end
        ST_CLR: begin
          if (sb.i_decoded_SB_msg == MSG_CLR_RESP) begin
            state_d = ST_SEND;
            if (cfg_valvref_q) begin
              cw_d  = CW_IDLE;
              ven_d = 1'b1;
            end else begin
              cw_d  = cfg_pattern_q ? CW_ID : CW_LFSR;
            end
          end else if (timeout) begin
            state_d = ST_ERROR;
          end
        end
        ST_SEND: begin
          if (i_pattern_finished) begin
            state_d = ST_CNT; msg_d = MSG_CNT_REQ; cw_d = CW_IDLE; ven_d = 1'b0;
            valid_d = 1'b1;
          end
        end
        ST_CNT: begin
          if (sb.i_decoded_SB_msg == MSG_CNT_RESP) begin
            iter_d  = iter_next[ITER_WIDTH-1:0];
            valid_d = 1'b1;
            if (iter_next < eff_iter) begin
              state_d = ST_CLR; msg_d = MSG_CLR_REQ; cw_d = CW_CLR;
            end else begin
              state_d = ST_END; msg_d = MSG_END_REQ;
            end
          end else if (timeout) begin
            state_d = ST_ERROR;
          end
        end
        ST_END: begin
          if (sb.i_decoded_SB_msg == MSG_END_RESP) begin
            state_d = ST_DONE; done_d = 1'b1;
          end else if (timeout) begin
            state_d = ST_ERROR;
          end
        end
        default: ; // DONE / ERROR hold until the enable drops
      endcase

      if ((state_q != ST_ERROR) && (state_d == ST_ERROR)) begin
        done_d = 1'b1; err_d = 1'b1; cw_d = CW_IDLE; ven_d = 1'b0;
      end
    end

    // Wait counter: cleared on entry, saturating count in waiting states.
    if (state_d != state_q)             wait_d = '0;
    else if (waiting && !timeout)       wait_d = wait_q + WAIT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      wait_q        <= '0;
      iter_q        <= '0;
      cfg_iter_q    <= '0;
      cfg_valvref_q <= 1'b0;
      cfg_pattern_q <= 1'b0;
      msg_q         <= '0;
      valid_q       <= 1'b0;
      pat_q         <= 1'b0;
      burst_q       <= 1'b0;
      cmp_q         <= 1'b0;
      phase_q       <= 2'b00;
      cw_q          <= CW_IDLE;
      ven_q         <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      iter_q        <= iter_d;
      cfg_iter_q    <= cfg_iter_d;
      cfg_valvref_q <= cfg_valvref_d;
      cfg_pattern_q <= cfg_pattern_d;
      msg_q         <= msg_d;
      valid_q       <= valid_d;
      pat_q         <= pat_d;
      burst_q       <= burst_d;
      cmp_q         <= cmp_d;
      phase_q       <= phase_d;
      cw_q          <= cw_d;
      ven_q         <= ven_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign sb.o_encoded_SB_msg_tx           = msg_q;
  assign sb.o_valid_tx                    = valid_q;
  assign sb.o_sb_data_pattern             = pat_q;
  assign sb.o_sb_burst_count              = burst_q;
  assign sb.o_sb_comparison_mode          = cmp_q;
  assign sb.o_clock_phase                 = phase_q;
  assign o_mainband_pattern_generator_cw  = cw_q;
  assign o_val_pattern_en                 = ven_q;
  assign o_iter_cnt                       = iter_q;
  assign o_pt_done_tx                     = done_q;
  assign o_pt_error                       = err_q;
  assign o_dbg_state                      = state_q;

endmodule

// File: tb/tb_rx_point_test_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_point_test_tx_ctrl
//   Directed bench for rx_point_test_tx_ctrl (TIMEOUT_CYCLES=16).
//   Every change of the observed output vector is popped by the monitor and
//   compared, including the cycle stamp at which it appeared, against an
//   entry the driver pushed when issuing the causing stimulus.
// ---------------------------------------------------------------------------
module tb_rx_point_test_tx_ctrl;

  localparam int SBW = 4;
  localparam int ITW = 4;
  localparam int VW  = 22;
  localparam int W   = 16 + VW;

  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_CLR = 3'd2, S_SEND = 3'd3,
                         S_CNT = 3'd4, S_END = 3'd5, S_DONE = 3'd6, S_ERR = 3'd7;

  logic           clk = 1'b0;
  logic           rst;
  logic           pt_en, valvref_sel, pattern_sel, burst_sel, compare_mode;
  logic [1:0]     clock_phase;
  logic [ITW-1:0] iterations;
  logic           pattern_finished;
  logic [1:0]     cw;
  logic           val_en, done, err;
  logic [ITW-1:0] iter_cnt;
  logic [2:0]     dbg_state;

  rx_point_test_tx_ctrl_if #(.SB_MSG_WIDTH(SBW)) sb_if ();

  rx_point_test_tx_ctrl #(
    .SB_MSG_WIDTH(SBW), .ITER_WIDTH(ITW), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pt_en(pt_en),
    .i_valvref_sel(valvref_sel), .i_pattern_sel(pattern_sel),
    .i_burst_sel(burst_sel), .i_compare_mode(compare_mode),
    .i_clock_phase(clock_phase), .i_iterations(iterations),
    .i_pattern_finished(pattern_finished), .sb(sb_if),
    .o_mainband_pattern_generator_cw(cw), .o_val_pattern_en(val_en),
    .o_iter_cnt(iter_cnt), .o_pt_done_tx(done), .o_pt_error(err),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  logic [2:0]     e_state;
  logic [SBW-1:0] e_msg;
  logic           e_valid, e_ven, e_done, e_err, e_pat, e_burst, e_cmp;
  logic [1:0]     e_cw, e_phase;
  logic [ITW-1:0] e_iter;

  function automatic logic [VW-1:0] obs_vec();
    return {dbg_state, sb_if.o_encoded_SB_msg_tx, sb_if.o_valid_tx, cw, val_en,
            iter_cnt, done, err, sb_if.o_sb_data_pattern, sb_if.o_sb_burst_count,
            sb_if.o_sb_comparison_mode, sb_if.o_clock_phase};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_state, e_msg, e_valid, e_cw, e_ven, e_iter, e_done, e_err,
            e_pat, e_burst, e_cmp, e_phase};
  endfunction

  task automatic clear_model();
    e_state = S_IDLE; e_msg = '0; e_valid = 0; e_cw = 0; e_ven = 0; e_iter = '0;
    e_done = 0; e_err = 0; e_pat = 0; e_burst = 0; e_cmp = 0; e_phase = 0;
  endtask

  // Expected change appears ofs cycles after the current cycle.
  task automatic push(input int ofs);
    logic [15:0] st;
    st = 16'(cyc + ofs);
    exp_q.push_back({st, exp_vec()});
  endtask

  // ---------------- monitor ----------------
  logic [VW-1:0] prev_vec;
  always @(negedge clk) begin
    logic [VW-1:0] v;
    logic [W-1:0]  got, exp;
    if (mon_en) begin
      v = obs_vec();
      if (v != prev_vec) begin
        got = {16'(cyc), v};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got cyc=%0d vec=%h, required no change", cyc, v);
        end else begin
          exp = exp_q.pop_front();
          if (got != exp) begin
            errors++;
            $display("FAIL out_change: got cyc=%0d vec=%h, required cyc=%0d vec=%h",
                     cyc, v, exp[W-1:VW], exp[VW-1:0]);
          end
        end
      end
      prev_vec = v;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic resp(input logic [SBW-1:0] code);
    sb_if.i_decoded_SB_msg = code;
    tick();
    sb_if.i_decoded_SB_msg = '0;
  endtask

  task automatic pat_done();
    pattern_finished = 1'b1;
    tick();
    pattern_finished = 1'b0;
  endtask

  task automatic start_test(input logic vv, input logic ps, input logic bs,
                            input logic cm, input logic [1:0] ph,
                            input logic [ITW-1:0] it, input logic exp_pat);
    valvref_sel = vv; pattern_sel = ps; burst_sel = bs; compare_mode = cm;
    clock_phase = ph; iterations = it;
    clear_model();
    e_state = S_START; e_msg = 4'd1; e_valid = 1; e_pat = exp_pat;
    e_burst = bs; e_cmp = cm; e_phase = ph;
    push(1);
    pt_en = 1'b1;
    tick();
  endtask

  // Disable: IDLE next cycle, outputs cleared the cycle after.
  task automatic stop_test();
    e_state = S_IDLE;
    push(1);
    clear_model();
    push(2);
    pt_en = 1'b0;
    ticks(3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; pt_en = 0; valvref_sel = 0; pattern_sel = 0; burst_sel = 0;
    compare_mode = 0; clock_phase = 0; iterations = 0; pattern_finished = 0;
    sb_if.i_decoded_SB_msg = '0; sb_if.i_falling_edge_busy = 0; sb_if.i_rx_valid = 0;
    clear_model();
    ticks(2);
    @(negedge clk);
    checks++;
    if (obs_vec() != '0) begin
      errors++;
      $display("FAIL reset_state: got vec=%h, required 0", obs_vec());
    end
    prev_vec = obs_vec();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    ticks(2);

    // 1: single data test, LFSR, 4K, config changes after start are ignored
    start_test(0, 0, 1, 0, 2'd0, 4'd1, 0);
    pattern_sel = 1; burst_sel = 0; iterations = 4'd5;
    ticks(2);
    e_state = S_CLR; e_msg = 4'd3; e_cw = 2'b01; push(1); resp(4'd2);
    e_state = S_SEND; e_cw = 2'b10; push(1); resp(4'd4);
    resp(4'd6);                 // unexpected in SEND: ignored
    ticks(20);                  // no timeout while sending
    e_state = S_CNT; e_msg = 4'd5; e_cw = 2'b00; push(1); pat_done();
    e_state = S_END; e_msg = 4'd7; e_iter = 4'd1; push(1); resp(4'd6);
    e_state = S_DONE; e_done = 1; push(1); resp(4'd8);
    ticks(2);
    stop_test();

    // 2: valid vref test, three iterations; pattern_sel masked off
    start_test(1, 1, 0, 1, 2'd2, 4'd3, 0);
    e_state = S_CLR; e_msg = 4'd3; e_cw = 2'b01; push(1); resp(4'd2);
    for (int i = 0; i < 3; i++) begin
      e_state = S_SEND; e_cw = 2'b00; e_ven = 1; push(1); resp(4'd4);
      tick();
      e_state = S_CNT; e_msg = 4'd5; e_ven = 0; push(1); pat_done();
      e_iter = 4'(i + 1);
      if (i < 2) begin
        e_state = S_CLR; e_msg = 4'd3; e_cw = 2'b01;
      end else begin
        e_state = S_END; e_msg = 4'd7;
      end
      push(1); resp(4'd6);
    end
    e_state = S_DONE; e_done = 1; push(1); resp(4'd8);
    stop_test();

    // 3a: LFSR_CLR_RESP withheld -> ERROR 16 cycles after entering CLR
    start_test(0, 0, 0, 0, 2'd1, 4'd1, 0);
    e_state = S_CLR; e_msg = 4'd3; e_cw = 2'b01; push(1); resp(4'd2);
    e_state = S_ERR; e_cw = 2'b00; e_done = 1; e_err = 1; push(16);
    ticks(18);
    resp(4'd4);                 // late response: stays in ERROR
    stop_test();

    // 3b: response in the last waiting cycle wins over the timeout
    start_test(0, 0, 0, 0, 2'd1, 4'd1, 0);
    e_state = S_CLR; e_msg = 4'd3; e_cw = 2'b01; push(1); resp(4'd2);
    ticks(15);
    e_state = S_SEND; e_cw = 2'b10; push(1); resp(4'd4);
    tick();

    // 4: disable during SEND, then restart
    stop_test();
    start_test(0, 0, 0, 0, 2'd1, 4'd1, 0);
    tick();
    stop_test();

    // 5: valid handshake arbitration
    start_test(0, 0, 1, 1, 2'd0, 4'd1, 0);
    sb_if.i_falling_edge_busy = 1; sb_if.i_rx_valid = 1;
    tick();                     // RX side busy: valid holds
    sb_if.i_rx_valid = 0;
    e_valid = 0; push(1);
    tick();
    sb_if.i_falling_edge_busy = 0;
    tick();
    sb_if.i_falling_edge_busy = 1;
    e_state = S_CLR; e_msg = 4'd3; e_cw = 2'b01; e_valid = 1; push(1);
    resp(4'd2);                 // new request in the same cycle: set wins
    sb_if.i_falling_edge_busy = 0;
    tick();
    stop_test();

    // 6: per-lane ID, zero iterations -> one pass; async reset during END
    start_test(0, 1, 0, 0, 2'd1, 4'd0, 1);
    e_state = S_CLR; e_msg = 4'd3; e_cw = 2'b01; push(1); resp(4'd2);
    e_state = S_SEND; e_cw = 2'b11; push(1); resp(4'd4);
    e_state = S_CNT; e_msg = 4'd5; e_cw = 2'b00; push(1); pat_done();
    e_state = S_END; e_msg = 4'd7; e_iter = 4'd1; push(1); resp(4'd6);
    tick();
    clear_model();
    push(0);                    // visible within the same cycle
    rst = 1'b1;
    pt_en = 1'b0;
    tick();
    rst = 1'b0;
    ticks(4);                   // nothing resent without an enable
    start_test(1, 0, 1, 1, 2'd2, 4'd2, 0);
    stop_test();

    ticks(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net: never run away.
  initial begin
    #100000;
    $display("FAIL sim_timeout: got no end by time %0t, required finish", $time);
    $fatal(1, "timeout");
  end

endmodule
